alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port stall, input, 1 bit: when high, no new request is granted.
REQ-005 SHALL have ports reqN_valid, input, 1 bit, N=0,1: requester N presents an operation.
REQ-006 SHALL have ports reqN_op, input, 4 bits: ALU opcode, encoded per the shared ALU opcode defines.
REQ-007 SHALL have ports reqN_a and reqN_b, input, DATA_WIDTH each: operands.
REQ-008 SHALL have ports reqN_ready, output, 1 bit: grant; a transfer occurs when reqN_valid and reqN_ready are both high at a rising edge.
REQ-009 SHALL have ports rspN_valid, output, 1 bit: one-cycle pulse marking that the result for requester N is valid.
REQ-010 SHALL have ports rspN_result, output, DATA_WIDTH: result for requester N.
REQ-011 SHALL have port alu_op, output, 4 bits: registered opcode driven to the shared ALU.
REQ-012 SHALL have ports alu_a and alu_b, output, DATA_WIDTH each: registered operands driven to the ALU.
REQ-013 SHALL have port alu_result, input, DATA_WIDTH: combinational result returned by the ALU.

Function
REQ-014 SHALL compute reqN_ready combinationally from stall, both valids and last_grant; reqN_ready is never high while reqN_valid is low.
REQ-015 SHALL grant no requester when stall=1.
REQ-016 SHALL grant the single valid requester when only one is valid and stall=0.
REQ-017 SHALL, when both are valid and stall=0, grant the port other than last_grant; exactly one ready is high.
REQ-018 SHALL update last_grant to the granted port on every transfer, and hold it otherwise.
REQ-019 SHALL, on a transfer, load issue-stage registers s1_valid=1, s1_port=N, alu_op=reqN_op, alu_a=reqN_a and alu_b=reqN_b at that edge.
REQ-020 SHALL clear s1_valid on an edge with no transfer, while alu_op, alu_a and alu_b hold their previous values.
REQ-021 SHALL, at the edge after s1_valid=1, register alu_result into rsp{s1_port}_result and pulse rsp{s1_port}_valid for exactly one cycle.
REQ-022 SHALL hold rspN_result between pulses and keep rspN_valid low for the other port.
REQ-023 SHALL give a latency of 2 cycles: transfer at edge E gives rspN_valid high in the cycle after edge E+1.
REQ-024 SHALL accept one transfer per cycle, fully pipelined, with no backpressure on responses.
REQ-025 SHALL keep the two requesters' responses ordered per grant order, never reordered or dropped.
REQ-026 SHALL, when stall rises with an operation in flight, still complete that operation and deliver its response.

Reset
REQ-027 SHALL, while rst_n=0, immediately force: s1_valid=0, s1_port=0, alu_op=0, alu_a=0, alu_b=0, rsp0_valid=0, rsp1_valid=0, rsp0_result=0, rsp1_result=0 and last_grant=1, so port 0 wins the first contention.
REQ-028 SHALL drop, without a response, any operation in flight when reset is asserted mid-operation.
REQ-029 SHALL keep reqN_ready low while rst_n=0.
REQ-030 SHALL resume granting at the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL cover single op: req0 ALU_ADD a=5 b=7 at edge 1 -> rsp0_valid pulse two cycles later with rsp0_result=12; rsp1_valid stays 0.
REQ-032 SHALL cover contention: both valid every cycle, req0 ALU_SUB 10,3 and req1 ALU_XOR 0xF0,0xFF -> grants alternate 0,1,0,1; results alternate 7 and 0x0F.
REQ-033 SHALL cover back-to-back: req1 ALU_SLL 1,n for n=0..3 on consecutive cycles -> four consecutive rsp1_valid pulses with results 1,2,4,8.
REQ-034 SHALL cover stall: stall=1 with req0 valid -> req0_ready=0 and no response; deassert stall -> ready next cycle, result arrives 2 cycles after the transfer.
REQ-035 SHALL cover reset mid-flight: transfer ALU_OR 3,4 then rst_n=0 one cycle later -> no rsp0_valid, all outputs 0; the first contention after reset grants port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared, externally computed ALU
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  req0_valid,
  input  logic [3:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [3:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  logic last_grant;
  logic s1_valid;
  logic s1_port;
  logic xfer;

  // rst_n gates the grants so nothing is accepted while reset is held
  always_comb begin
    req0_ready = rst_n && !stall && req0_valid && (!req1_valid || last_grant);
    req1_ready = rst_n && !stall && req1_valid && (!req0_valid || !last_grant);
    xfer       = req0_ready || req1_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      s1_valid    <= 1'b0;
      s1_port     <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_result <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        last_grant <= req1_ready;
        s1_port    <= req1_ready;
        alu_op     <= req1_ready ? req1_op : req0_op;
        alu_a      <= req1_ready ? req1_a  : req0_a;
        alu_b      <= req1_ready ? req1_b  : req0_b;
      end
      // ALU result is combinational on the issue registers, so capture it one edge later
      rsp0_valid <= s1_valid && !s1_port;
      rsp1_valid <= s1_valid && s1_port;
      if (s1_valid && !s1_port) rsp0_result <= alu_result;
      if (s1_valid && s1_port)  rsp1_result <= alu_result;
    end
  end

endmodule
